// File: rtl/frame_beat_tracker_if.sv
// Size/command and data-beat signals between the command source and frame_beat_tracker.
// The master drives size and beats; the slave (the tracker) returns ready, last, keep and status.
interface frame_beat_tracker_if #(
    parameter int CNT_W = 32,
    parameter int LANES = 4
);
    logic [CNT_W-1:0] size;
    logic             size_valid;
    logic             size_ready;
    logic             data_start;
    logic             data_valid;
    logic             last;
    logic [LANES-1:0] keep;
    logic             busy;
    logic             err_size;
    logic             err_proto;

    modport master (
        output size, size_valid, data_start, data_valid,
        input  size_ready, last, keep, busy, err_size, err_proto
    );

    modport slave (
        input  size, size_valid, data_start, data_valid,
        output size_ready, last, keep, busy, err_size, err_proto
    );
endinterface

// File: rtl/frame_beat_tracker.sv
// Tracks beats of LANES-byte-wide frames: flags the final beat with last/keep and
// holds one pending length so frames can run back-to-back.
module frame_beat_tracker #(
    parameter int CNT_W = 32,
    parameter int LANES = 4
) (
    input logic                 clock,
    input logic                 rst_n,
    frame_beat_tracker_if.slave bus
);
    localparam int SHIFT  = $clog2(LANES);
    localparam int TAIL_W = (LANES > 1) ? SHIFT : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COUNT
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [TAIL_W-1:0] tail_q, tail_d;
    logic              pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]  pend_beats_q, pend_beats_d;
    logic [TAIL_W-1:0] pend_tail_q, pend_tail_d;
    logic              err_size_q, err_size_d;
    logic              err_proto_q, err_proto_d;

    logic [CNT_W-1:0]  beats_in;
    logic [TAIL_W-1:0] tail_in;
    logic              size_ready;
    logic              size_fire;
    logic              size_load;
    logic              beat;
    logic              last;
    logic [LANES-1:0]  keep_mask;

    // The extra bit keeps size = 2^CNT_W-1 from wrapping before the divide.
    assign beats_in = CNT_W'(({1'b0, bus.size} + (CNT_W + 1)'(LANES - 1)) >> SHIFT);
    assign tail_in  = (LANES == 1) ? '0 : bus.size[TAIL_W-1:0];

    assign size_ready = rst_n && ((state_q == S_IDLE) || !pend_valid_q);
    assign size_fire  = bus.size_valid && size_ready;
    assign size_load  = size_fire && (bus.size != '0);

    always_comb begin
        beat = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_ARMED: beat = bus.data_valid && bus.data_start;
                S_COUNT: beat = bus.data_valid;
                default: beat = 1'b0;
            endcase
        end
    end

    assign last = beat && (remaining_q == CNT_W'(1));

    always_comb begin
        keep_mask = '1;
        if (last && (tail_q != '0)) begin
            for (int i = 0; i < LANES; i++) begin
                keep_mask[i] = (TAIL_W'(i) < tail_q);
            end
        end
    end

    // NOTE: every variable gets its hold value before the case, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        tail_d       = tail_q;
        pend_valid_d = pend_valid_q;
        pend_beats_d = pend_beats_q;
        pend_tail_d  = pend_tail_q;
        err_size_d   = size_fire && (bus.size == '0);
        err_proto_d  = bus.data_valid &&
                       ((state_q == S_IDLE) ||
                        ((state_q == S_ARMED) && !bus.data_start) ||
                        ((state_q == S_COUNT) && bus.data_start));

        if (beat) begin
            remaining_d = remaining_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (size_load) begin
                    remaining_d = beats_in;
                    tail_d      = tail_in;
                    state_d     = S_ARMED;
                end
            end
            S_ARMED, S_COUNT: begin
                if (beat && !last && (state_q == S_ARMED)) begin
                    state_d = S_COUNT;
                end
                if (last) begin
                    if (pend_valid_q) begin
                        remaining_d  = pend_beats_q;
                        tail_d       = pend_tail_q;
                        pend_valid_d = 1'b0;
                        state_d      = S_ARMED;
                    end else if (size_load) begin
                        remaining_d = beats_in;
                        tail_d      = tail_in;
                        state_d     = S_ARMED;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (size_load) begin
                    // size_ready guarantees the slot is empty here.
                    pend_valid_d = 1'b1;
                    pend_beats_d = beats_in;
                    pend_tail_d  = tail_in;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            tail_q       <= '0;
            pend_valid_q <= 1'b0;
            err_size_q   <= 1'b0;
            err_proto_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            tail_q       <= tail_d;
            pend_valid_q <= pend_valid_d;
            err_size_q   <= err_size_d;
            err_proto_q  <= err_proto_d;
        end
    end

    // NOTE: the pending payload is left unreset; it is only ever read while pend_valid_q is set.
    always_ff @(posedge clock) begin
        pend_beats_q <= pend_beats_d;
        pend_tail_q  <= pend_tail_d;
    end

    assign bus.size_ready = size_ready;
    assign bus.last       = last;
    assign bus.keep       = keep_mask;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.err_size   = err_size_q;
    assign bus.err_proto  = err_proto_q;
endmodule

// File: tb/tb_frame_beat_tracker.sv
// Directed-vector bench for frame_beat_tracker (CNT_W=8, LANES=4) with hand-computed expectations.
module tb_frame_beat_tracker;
    logic clock;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    frame_beat_tracker_if #(.CNT_W(8), .LANES(4)) bif ();

    frame_beat_tracker #(.CNT_W(8), .LANES(4)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then return inputs to idle and let outputs settle.
    task automatic step();
        @(posedge clock);
        #1;
        bif.size_valid = 1'b0;
        bif.size       = '0;
        bif.data_valid = 1'b0;
        bif.data_start = 1'b0;
        #1;
    endtask

    task automatic drive(input logic sv, input logic [7:0] sz, input logic dv, input logic ds);
        bif.size_valid = sv;
        bif.size       = sz;
        bif.data_valid = dv;
        bif.data_start = ds;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bif.size_valid = 1'b0;
        bif.size       = '0;
        bif.data_valid = 1'b0;
        bif.data_start = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        check("rst_size_ready", bif.size_ready, 0);
        check("rst_busy", bif.busy, 0);
        check("rst_last", bif.last, 0);
        check("rst_keep", bif.keep, 4'hF);
        check("rst_err_size", bif.err_size, 0);
        check("rst_err_proto", bif.err_proto, 0);
        rst_n = 1'b1;
        #1;
        check("rel_size_ready", bif.size_ready, 1);

        // size=10: three beats, tail of two bytes
        drive(1, 8'd10, 0, 0);
        check("s10_ready", bif.size_ready, 1);
        step();
        check("s10_busy", bif.busy, 1);
        drive(0, 0, 1, 1);
        check("s10_b1_last", bif.last, 0);
        check("s10_b1_keep", bif.keep, 4'hF);
        step();
        drive(0, 0, 1, 0);
        check("s10_b2_last", bif.last, 0);
        step();
        drive(0, 0, 1, 0);
        check("s10_b3_last", bif.last, 1);
        check("s10_b3_keep", bif.keep, 4'h3);
        step();
        check("s10_idle_busy", bif.busy, 0);
        check("s10_err_proto", bif.err_proto, 0);

        // size=4 and size=1: single-beat frames
        drive(1, 8'd4, 0, 0);
        step();
        drive(0, 0, 1, 1);
        check("s4_last", bif.last, 1);
        check("s4_keep", bif.keep, 4'hF);
        step();
        check("s4_busy", bif.busy, 0);
        drive(1, 8'd1, 0, 0);
        step();
        drive(0, 0, 1, 1);
        check("s1_last", bif.last, 1);
        check("s1_keep", bif.keep, 4'h1);
        step();
        check("s1_busy", bif.busy, 0);

        // size=8 active with size=5 queued into the pending slot
        drive(1, 8'd8, 0, 0);
        step();
        drive(1, 8'd5, 1, 1);
        check("pend_ready_before", bif.size_ready, 1);
        check("pend_f1b1_last", bif.last, 0);
        step();
        check("pend_ready_full", bif.size_ready, 0);
        check("pend_busy", bif.busy, 1);
        drive(0, 0, 1, 0);
        check("pend_f1b2_last", bif.last, 1);
        check("pend_f1b2_keep", bif.keep, 4'hF);
        step();
        check("pend_armed_busy", bif.busy, 1);
        check("pend_armed_ready", bif.size_ready, 1);
        drive(0, 0, 1, 1);
        check("pend_f2b1_last", bif.last, 0);
        check("pend_f2b1_keep", bif.keep, 4'hF);
        step();
        check("pend_f2b1_proto", bif.err_proto, 0);
        drive(0, 0, 1, 0);
        check("pend_f2b2_last", bif.last, 1);
        check("pend_f2b2_keep", bif.keep, 4'h1);
        step();
        check("pend_done_busy", bif.busy, 0);

        // zero size, then a beat in IDLE
        drive(1, 8'd0, 0, 0);
        check("zero_ready", bif.size_ready, 1);
        step();
        check("zero_err_size", bif.err_size, 1);
        check("zero_busy", bif.busy, 0);
        drive(0, 0, 1, 1);
        check("idle_beat_last", bif.last, 0);
        step();
        check("zero_err_size_end", bif.err_size, 0);
        check("idle_err_proto", bif.err_proto, 1);
        check("idle_busy", bif.busy, 0);
        step();
        check("idle_err_proto_end", bif.err_proto, 0);

        // ARMED beat without start is ignored; start in COUNT still counts
        drive(1, 8'd8, 0, 0);
        step();
        drive(0, 0, 1, 0);
        check("armed_nostart_last", bif.last, 0);
        step();
        check("armed_nostart_proto", bif.err_proto, 1);
        check("armed_nostart_busy", bif.busy, 1);
        drive(0, 0, 1, 1);
        check("armed_start_last", bif.last, 0);
        step();
        check("armed_start_proto", bif.err_proto, 0);
        drive(0, 0, 1, 1);
        check("count_start_last", bif.last, 1);
        check("count_start_keep", bif.keep, 4'hF);
        step();
        check("count_start_proto", bif.err_proto, 1);
        check("count_start_busy", bif.busy, 0);

        // size=255 on an 8-bit counter: 64 beats, last keep 0111
        drive(1, 8'd255, 0, 0);
        step();
        for (int b = 1; b <= 64; b++) begin
            drive(0, 0, 1, b == 1);
            check($sformatf("s255_b%0d_last", b), bif.last, (b == 64) ? 1 : 0);
            if (b == 64) check("s255_keep", bif.keep, 4'h7);
            step();
        end
        check("s255_busy", bif.busy, 0);

        // reset on beat 30 with a size pending: frame and pending size are discarded
        drive(1, 8'd255, 0, 0);
        step();
        for (int b = 1; b <= 29; b++) begin
            drive(b == 2, 8'd4, 1, b == 1);
            step();
        end
        check("mid_ready_full", bif.size_ready, 0);
        drive(0, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", bif.size_ready, 0);
        check("mid_rst_last", bif.last, 0);
        step();
        check("mid_rst_busy", bif.busy, 0);
        check("mid_rst_keep", bif.keep, 4'hF);
        check("mid_rst_err_size", bif.err_size, 0);
        check("mid_rst_err_proto", bif.err_proto, 0);
        check("mid_rst_ready2", bif.size_ready, 0);
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", bif.size_ready, 1);
        check("mid_rel_busy", bif.busy, 0);
        drive(0, 0, 1, 1);
        check("mid_rel_last", bif.last, 0);
        step();
        check("mid_rel_proto", bif.err_proto, 1);
        check("mid_rel_busy2", bif.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_beat_tracker.md
# frame_beat_tracker

Parametrised successor to the single-size down-counter in the Adler-32 checksum front end. The block accepts a frame length in bytes and tracks the data beats of a bus that carries LANES bytes per beat. It flags the final beat with `last` and a byte-valid mask, and holds one pending length so frames can run back-to-back. It sits between the size/command source and the checksum datapath, replacing the one-beat-per-byte counter.

## Interface
- CNT_W, 32: width of `size` and of the internal beat counter.
- LANES, 4: bytes per data beat. Must be a power of two and ≥1; LANES=1 reproduces byte-serial operation.

- clock  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- size  in  CNT_W  frame length in bytes.
- size_valid  in  1  `size` is offered.
- size_ready  out  1  block can accept `size` this cycle; a transfer occurs when `size_valid && size_ready`.
- data_start  in  1  marks the first beat of a frame; meaningful only with `data_valid`.
- data_valid  in  1  a data beat is present on the bus this cycle.
- last  out  1  the current beat is the final beat of the active frame (combinational).
- keep  out  LANES  byte-valid mask for the current beat (combinational).
- busy  out  1  a frame is active (ARMED or COUNT).
- err_size  out  1  registered 1-cycle pulse: a zero `size` was offered and dropped.
- err_proto  out  1  registered 1-cycle pulse: protocol violation on the data side.

## Operation
- States:
  - IDLE: no active frame.
  - ARMED: length loaded, waiting for the start beat.
  - COUNT: mid-frame.
- Size load: beats = ceil(size/LANES), computed in CNT_W+1 bits so size = 2^CNT_W−1 cannot overflow. Stored in `remaining`. Tail = size mod LANES.
- size_ready = 1 in IDLE, or when the pending slot is empty. It is 0 while rst_n is low.
- size acceptance:
  - Accepted in IDLE: loads the active registers; next state is ARMED.
  - Accepted in ARMED or COUNT: stored in the pending slot.
- Zero size: the handshake completes but nothing is stored. err_size pulses the next cycle and the state is unchanged.
- Beat acceptance:
  - ARMED: beat = data_valid && data_start.
  - COUNT: beat = data_valid.
  - `remaining` decrements by 1 on each accepted beat.
- last = beat && remaining==1.
- keep:
  - When last=1 and tail≠0: the low `tail` bits are set.
  - In all other cases: all ones.
- Transitions:
  - ARMED: a start beat with remaining>1 goes to COUNT. A start beat with remaining==1 is a single-beat frame: last asserts on that start beat.
  - COUNT: the last beat ends the frame.
  - End of frame:
    - Pending slot valid: pending moves to active, the slot clears, next state is ARMED.
    - Else, a size accepted in the same cycle goes directly to active and the next state is ARMED.
    - Else, next state is IDLE.
- err_proto pulses the cycle after any of these:
  - data_valid in IDLE (beat ignored).
  - data_valid without data_start in ARMED (beat ignored).
  - data_valid && data_start in COUNT (counted as an ordinary beat).
- busy = (state != IDLE).

## Timing
- Reset (rst_n low at a clock edge):
  - state=IDLE; remaining=0; pending slot empty.
  - err_size=0, err_proto=0.
  - last=0, keep=all ones, busy=0, size_ready=0 (size_ready=0 only while rst_n is low).
- First cycle after release: size_ready=1.
- Reset mid-frame aborts the frame: no last is issued and the pending size is discarded.
- last and keep are valid in the same cycle as the qualifying beat (zero latency). The first beat of the next frame can arrive on the cycle after last.
- Size-to-start latency: a size accepted at edge N allows a start beat in cycle N+1.
- err pulses are high for exactly one cycle, one cycle after the offending input.

## Test plan
- LANES=4, size=10 accepted, start plus 3 beats: last on beat 3 only, keep=4'b0011 on beat 3, then IDLE, busy=0.
- size=4: last asserts on the start beat with keep=4'b1111; size=1 gives keep=4'b0001 on the start beat.
- size=8 active; size=5 accepted mid-frame, after which size_ready=0. After the last beat of frame 1: state ARMED, size_ready=1. Frame 2 takes 2 beats with keep=4'b0001 on beat 2.
- size=0 offered: err_size pulses one cycle later, state stays IDLE, no beat is tracked.
- Protocol errors:
  - data_valid in IDLE gives err_proto.
  - data_valid without start in ARMED gives err_proto and `remaining` is unchanged.
  - data_start in COUNT gives err_proto and the beat still counts.
- CNT_W=8, LANES=4, size=255: 64 beats, last keep=4'b0111. rst_n low on beat 30 gives no last; outputs at reset values and size_ready=0 during reset, then size_ready=1 the cycle after release.
